// File: rtl/seq_sub_divider.sv
// seq_sub_divider: 8-bit unsigned divider by repeated subtraction, one subtract-compare step per clock.
// Latency: START accepted at edge 0, DONE high after edge Q+1 (after edge 0 for a zero divisor).
// Backpressure: none; START is sampled only in IDLE and ignored while the block is busy or finishing.
//
// Ports:
//   CLK, RESET          rising-edge clock, asynchronous active-low reset
//   START               request, sampled only in IDLE together with DIVIDEND/DIVISOR
//   DIVIDEND, DIVISOR   8-bit unsigned operands
//   BUSY                high while subtracting (SUB state)
//   DONE                one-cycle completion pulse (FIN state)
//   DIV_ZERO            set by a zero-divisor request, cleared by the next accepted START
//   QUOT, REM           registered results, held until the next completion
//   QUOT_LSB/MSB        active-low gfedcba 7-segment patterns of QUOT nibbles
//   REM_LSB/MSB         active-low gfedcba 7-segment patterns of REM nibbles
//
// Build option: define SEQDIV_HEX_SEG_EN to show nibbles 10-15 as A b C d E F;
// without it those nibbles are blanked. Arithmetic and timing are the same in both builds.

module seq_sub_divider (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [7:0] DIVIDEND,
   input  logic [7:0] DIVISOR,
   output logic       BUSY,
   output logic       DONE,
   output logic       DIV_ZERO,
   output logic [7:0] QUOT,
   output logic [7:0] REM,
   output logic [6:0] QUOT_LSB,
   output logic [6:0] QUOT_MSB,
   output logic [6:0] REM_LSB,
   output logic [6:0] REM_MSB
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SUB  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   // Working remainder, divisor copy and subtraction count.
   logic [7:0] r_wrem;
   logic [7:0] r_dcopy;
   logic [7:0] r_cnt;

   // Visible results.
   logic [7:0] r_quot;
   logic [7:0] r_rem;
   logic       r_div_zero;

   logic [7:0] w_wrem_nxt;
   logic [7:0] w_dcopy_nxt;
   logic [7:0] w_cnt_nxt;
   logic [7:0] w_quot_nxt;
   logic [7:0] w_rem_nxt;
   logic       w_div_zero_nxt;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= S_IDLE;
         r_wrem     <= 8'd0;
         r_dcopy    <= 8'd0;
         r_cnt      <= 8'd0;
         r_quot     <= 8'd0;
         r_rem      <= 8'd0;
         r_div_zero <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wrem     <= w_wrem_nxt;
         r_dcopy    <= w_dcopy_nxt;
         r_cnt      <= w_cnt_nxt;
         r_quot     <= w_quot_nxt;
         r_rem      <= w_rem_nxt;
         r_div_zero <= w_div_zero_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wrem_nxt     = r_wrem;
      w_dcopy_nxt    = r_dcopy;
      w_cnt_nxt      = r_cnt;
      w_quot_nxt     = r_quot;
      w_rem_nxt      = r_rem;
      w_div_zero_nxt = r_div_zero;

      case (r_state)
         S_IDLE: begin
            if (START) begin
               if (DIVISOR != 8'd0) begin
                  w_wrem_nxt     = DIVIDEND;
                  w_dcopy_nxt    = DIVISOR;
                  w_cnt_nxt      = 8'd0;
                  w_div_zero_nxt = 1'b0;
                  w_state_nxt    = S_SUB;
               end else begin
                  // Zero divisor: report saturated quotient, skip the subtract loop.
                  w_quot_nxt     = 8'hFF;
                  w_rem_nxt      = DIVIDEND;
                  w_div_zero_nxt = 1'b1;
                  w_state_nxt    = S_FIN;
               end
            end
         end

         S_SUB: begin
            // The compare guards the subtract, so R never underflows and the
            // count tops out at 255 (255/1).
            if (r_wrem >= r_dcopy) begin
               w_wrem_nxt = r_wrem - r_dcopy;
               w_cnt_nxt  = r_cnt + 8'd1;
            end else begin
               w_quot_nxt  = r_cnt;
               w_rem_nxt   = r_wrem;
               w_state_nxt = S_FIN;
            end
         end

         S_FIN: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign BUSY     = (r_state == S_SUB);
   assign DONE     = (r_state == S_FIN);
   assign DIV_ZERO = r_div_zero;
   assign QUOT     = r_quot;
   assign REM      = r_rem;

   // Active-low gfedcba pattern for one nibble.
   function automatic logic [6:0] f_seg(input logic [3:0] i_nib);
      logic [6:0] w_pat;
      w_pat = 7'b1111111;
      case (i_nib)
         4'h0: w_pat = 7'b1000000;
         4'h1: w_pat = 7'b1111001;
         4'h2: w_pat = 7'b0100100;
         4'h3: w_pat = 7'b0110000;
         4'h4: w_pat = 7'b0011001;
         4'h5: w_pat = 7'b0010010;
         4'h6: w_pat = 7'b0000010;
         4'h7: w_pat = 7'b1111000;
         4'h8: w_pat = 7'b0000000;
         4'h9: w_pat = 7'b0010000;
`ifdef SEQDIV_HEX_SEG_EN
         4'hA: w_pat = 7'b0001000;
         4'hB: w_pat = 7'b0000011;
         4'hC: w_pat = 7'b1000110;
         4'hD: w_pat = 7'b0100001;
         4'hE: w_pat = 7'b0000110;
         4'hF: w_pat = 7'b0001110;
`else
         // Decimal-only display: hex digits are blanked.
         default: w_pat = 7'b1111111;
`endif
      endcase
      return w_pat;
   endfunction

   assign QUOT_LSB = f_seg(r_quot[3:0]);
   assign QUOT_MSB = f_seg(r_quot[7:4]);
   assign REM_LSB  = f_seg(r_rem[3:0]);
   assign REM_MSB  = f_seg(r_rem[7:4]);

endmodule

// File: tb/tb_seq_sub_divider.sv
// Bench for seq_sub_divider: randomized and directed requests against a
// plain-arithmetic reference; expected completions are queued at acceptance
// and a separate monitor checks every cycle and every DONE pulse.

module tb_seq_sub_divider;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       START = 1'b0;
   logic [7:0] DIVIDEND = 8'd0;
   logic [7:0] DIVISOR = 8'd0;
   logic       BUSY, DONE, DIV_ZERO;
   logic [7:0] QUOT, REM;
   logic [6:0] QUOT_LSB, QUOT_MSB, REM_LSB, REM_MSB;

   seq_sub_divider dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .DIVIDEND (DIVIDEND),
      .DIVISOR  (DIVISOR),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .DIV_ZERO (DIV_ZERO),
      .QUOT     (QUOT),
      .REM      (REM),
      .QUOT_LSB (QUOT_LSB),
      .QUOT_MSB (QUOT_MSB),
      .REM_LSB  (REM_LSB),
      .REM_MSB  (REM_MSB)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         cyc;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;

   // Reference timeline state (edge numbers).
   int cyc = 0;
   int idle_from = 0;
   int b_lo = 1;
   int b_hi = 0;
   int pend_cyc = -1;
   logic [7:0] pend_q = 8'd0;
   logic [7:0] pend_r = 8'd0;
   logic [7:0] held_q = 8'd0;
   logic [7:0] held_r = 8'd0;
   logic       held_dz = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] tbl [16];
      tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000,
`ifdef SEQDIV_HEX_SEG_EN
              7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001,
              7'b0000110, 7'b0001110};
`else
              7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
              7'b1111111, 7'b1111111};
`endif
      return tbl[n];
   endfunction

   // Reference: at each rising edge decide acceptance from the request
   // timeline and compute results with ordinary division.
   always @(posedge CLK) begin
      exp_t e;
      cyc = cyc + 1;
      if (RESET) begin
         if (pend_cyc == cyc) begin
            held_q = pend_q;
            held_r = pend_r;
         end
         if (START && cyc >= idle_from + 1) begin
            if (DIVISOR == 8'd0) begin
               e.cyc = cyc;
               e.q   = 8'hFF;
               e.r   = DIVIDEND;
               e.dz  = 1'b1;
               held_q  = 8'hFF;
               held_r  = DIVIDEND;
               held_dz = 1'b1;
            end else begin
               e.q   = DIVIDEND / DIVISOR;
               e.r   = DIVIDEND % DIVISOR;
               e.dz  = 1'b0;
               e.cyc = cyc + int'(e.q) + 1;
               b_lo  = cyc;
               b_hi  = cyc + int'(e.q);
               held_dz  = 1'b0;
               pend_cyc = e.cyc;
               pend_q   = e.q;
               pend_r   = e.r;
            end
            idle_from = e.cyc + 1;
            sb.push_back(e);
         end
      end
   end

   // Monitor: sampled on the falling edge.
   always @(negedge CLK) begin
      exp_t e;
      bit exp_done;
      exp_done = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk("done", int'(DONE), int'(exp_done));
      chk("busy", int'(BUSY), int'(cyc >= b_lo && cyc <= b_hi));
      chk("quot_hold", int'(QUOT), int'(held_q));
      chk("rem_hold", int'(REM), int'(held_r));
      chk("dz_hold", int'(DIV_ZERO), int'(held_dz));
      chk("seg_ql", int'(QUOT_LSB), int'(seg_of(held_q[3:0])));
      chk("seg_qm", int'(QUOT_MSB), int'(seg_of(held_q[7:4])));
      chk("seg_rl", int'(REM_LSB), int'(seg_of(held_r[3:0])));
      chk("seg_rm", int'(REM_MSB), int'(seg_of(held_r[7:4])));
      if (exp_done) begin
         e = sb.pop_front();
         done_cnt++;
         chk("sb_quot", int'(QUOT), int'(e.q));
         chk("sb_rem", int'(REM), int'(e.r));
         chk("sb_dz", int'(DIV_ZERO), int'(e.dz));
      end
   end

   // Caller is positioned just after a falling edge.
   task automatic do_reset();
      RESET = 1'b0;
      START = 1'b0;
      sb.delete();
      held_q = 8'd0;
      held_r = 8'd0;
      held_dz = 1'b0;
      b_lo = 1;
      b_hi = 0;
      pend_cyc = -1;
      idle_from = 0;
      @(negedge CLK);
      chk("rst_quot_lsb", int'(QUOT_LSB), int'(7'b1000000));
      chk("rst_rem_msb", int'(REM_MSB), int'(7'b1000000));
      chk("rst_busy_done", int'({BUSY, DONE, DIV_ZERO}), 0);
      @(negedge CLK);
      #1;
      RESET = 1'b1;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge CLK);
         if (sb.size() == 0 && cyc >= idle_from) ok = 1'b1;
      end
      #1;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL wait_idle: timeout with %0d outstanding results", sb.size());
      end
   endtask

   // One-cycle START pulse presented when the reference says the block is idle.
   task automatic issue(input logic [7:0] a, input logic [7:0] b);
      for (int i = 0; i < 600 && cyc < idle_from; i++) @(negedge CLK);
      #1;
      START = 1'b1;
      DIVIDEND = a;
      DIVISOR = b;
      @(negedge CLK);
      #1;
      START = 1'b0;
      DIVIDEND = 8'($urandom);
      DIVISOR = 8'($urandom);
   endtask

   task automatic expect_res(input int q, input int r, input int dz, input string tag);
      chk({tag, "_quot"}, int'(QUOT), q);
      chk({tag, "_rem"}, int'(REM), r);
      chk({tag, "_dz"}, int'(DIV_ZERO), dz);
   endtask

   initial begin
      #1;
      @(negedge CLK);
      #1;
      do_reset();

      // 100/7 with display check
      issue(8'd100, 8'd7);
      wait_idle();
      expect_res(14, 2, 0, "d100_7");
      chk("d100_7_qmsb", int'(QUOT_MSB), int'(7'b1000000));
`ifdef SEQDIV_HEX_SEG_EN
      chk("d100_7_qlsb", int'(QUOT_LSB), int'(7'b0000110));
`else
      chk("d100_7_qlsb", int'(QUOT_LSB), int'(7'b1111111));
`endif

      // Worst-case length then a single-step run
      issue(8'd255, 8'd1);
      wait_idle();
      expect_res(255, 0, 0, "d255_1");
      issue(8'd5, 8'd9);
      wait_idle();
      expect_res(0, 5, 0, "d5_9");

      // Zero divisor, then a normal run clears the flag
      issue(8'd200, 8'd0);
      wait_idle();
      expect_res(255, 200, 1, "d200_0");
      issue(8'd9, 8'd3);
      wait_idle();
      expect_res(3, 0, 0, "d9_3");

      // Second request during an active run is ignored
      begin
         int d0;
         d0 = done_cnt;
         issue(8'd100, 8'd7);
         repeat (3) @(negedge CLK);
         #1;
         START = 1'b1;
         DIVIDEND = 8'd50;
         DIVISOR = 8'd5;
         @(negedge CLK);
         #1;
         START = 1'b0;
         wait_idle();
         expect_res(14, 2, 0, "ignored");
         chk("ignored_done_count", done_cnt - d0, 1);
      end

      // Reset during SUB aborts the run
      issue(8'd100, 8'd7);
      repeat (4) @(negedge CLK);
      #1;
      do_reset();
      issue(8'd20, 8'd6);
      wait_idle();
      expect_res(3, 2, 0, "d20_6");

      // START held high: back-to-back runs
      begin
         int d0;
         d0 = done_cnt;
         @(negedge CLK);
         #1;
         START = 1'b1;
         DIVIDEND = 8'd8;
         DIVISOR = 8'd4;
         for (int i = 0; i < 100 && done_cnt < d0 + 3; i++) @(negedge CLK);
         #1;
         START = 1'b0;
         chk("held_done_count_min", int'(done_cnt >= d0 + 3), 1);
         wait_idle();
         expect_res(2, 0, 0, "held");
      end

      // Randomized requests with random gaps
      for (int n = 0; n < 40; n++) begin
         logic [7:0] a, b;
         int mode;
         a = 8'($urandom_range(0, 255));
         mode = $urandom_range(0, 7);
         if (mode == 0) b = 8'd0;
         else if (mode <= 3) b = 8'($urandom_range(1, 15));
         else b = 8'($urandom_range(1, 255));
         issue(a, b);
         if ($urandom_range(0, 1) == 1) begin
            wait_idle();
            if (b == 8'd0) expect_res(255, int'(a), 1, "rnd");
            else expect_res(int'(a / b), int'(a % b), 0, "rnd");
         end
         repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
